// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// mem_stage_dmem_ctrl_pkg: size encodings, FSM states and lane helpers for the MEM-stage data memory controller
package mem_stage_dmem_ctrl_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_BYTE ? 4'b0001 << off : sz == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] d);
    return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? off[0] : off != 2'b00;
  endfunction
endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// mem_stage_dmem_ctrl_if: req/ack data memory bus between the MEM-stage controller and the memory
interface mem_stage_dmem_ctrl_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  modport master(output mem_req, mem_we, mem_be, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_be, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage_dmem_ctrl_load_ext.sv
// mem_stage_dmem_ctrl_load_ext: picks the addressed byte/half of a read word and sign/zero-extends it
module mem_stage_dmem_ctrl_load_ext
  import mem_stage_dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select then extension; word loads pass straight through
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    data = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : word;
  end
endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: MEM-stage req/ack data memory controller with stall and load extension (optional DMEM_ALIGN_CHECK_EN)
module mem_stage_dmem_ctrl
  import mem_stage_dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              dmem_ena,
  input  logic              dmem_wena,
  input  logic [1:0]        dmem_wsel,
  input  logic [1:0]        dmem_rsel,
  input  logic              modifier_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              bus_err,
  output logic              addr_err,
  mem_stage_dmem_ctrl_if.master mem
);
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, sign_q, sign_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, load_data_q, load_data_d, ext_data;
  logic              load_valid_q, load_valid_d, bus_err_q, bus_err_d, addr_err_q, addr_err_d;
  mem_stage_dmem_ctrl_load_ext u_ext (.size(size_q), .sign(sign_q), .off(off_q), .word(mem.mem_rdata), .data(ext_data));
  // next state, latched access fields and one-cycle result pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    sign_d       = sign_q;
    size_d       = size_q;
    off_d        = off_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    addr_err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (dmem_ena) begin
        size_d  = dmem_wena ? dmem_wsel : dmem_rsel;
        sign_d  = modifier_sign;
        off_d   = addr[1:0];
        we_d    = dmem_wena;
        be_d    = dmem_wena ? be_of(size_d, addr[1:0]) : 4'b1111;
        addr_d  = {addr[ADDR_W-1:2], 2'b00};
        wdata_d = rep_of(size_d, wdata);
        cnt_d   = '0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (misaligned(size_d, addr[1:0])) begin
          addr_err_d  = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end else begin
          req_d   = 1'b1;
          state_d = REQ;
        end
`else
        req_d   = 1'b1;
        state_d = REQ;
`endif
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            load_data_d  = ext_data;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == LAST) begin
          req_d       = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end
      end
      DONE: state_d = ena ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously so mem_req drops the moment rst rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= SZ_WORD;
      off_q        <= 2'b00;
      be_q         <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      sign_q       <= sign_d;
      size_q       <= size_d;
      off_q        <= off_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      addr_err_q   <= addr_err_d;
    end
  end
  assign stall         = ~rst & (state_q == REQ | (state_q == IDLE & dmem_ena));
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign bus_err       = bus_err_q;
  assign addr_err      = addr_err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
endmodule
